multi_sprite_renderer: RTL and testbench
========================================

# multi_sprite_renderer

Parametrised successor to the single-sprite renderer: composites `NUM_SPRITES` independently positioned 16-colour-plane (RGBA) sprites onto the VGA raster with fixed index priority and per-frame collision detection. It sits between the hvsync generator and the registered `vga_R/G/B` outputs in the top level. A shared, externally supplied bitmap ROM is fetched sprite-by-sprite during horizontal blanking. Position updates go through shadow registers committed at frame start, so frames never tear.

## Interface

Parameters:
- `NUM_SPRITES`, 4: number of sprites (1..8).
- `SPRITE_W`, 16: sprite width in pixels.
- `SPRITE_H`, 16: sprite height in lines (power of two).
- `V_TOTAL`, 525: lines per frame, used for next-line wrap.
- `IDX_W`, `$clog2(NUM_SPRITES)` (min 1): sprite index width.

Ports:
- `clk` in 1: pixel clock, the PLL output.
- `reset` in 1: synchronous, active-high.
- `hpos` in 10: current pixel column from syncgen.
- `vpos` in 10: current line from syncgen.
- `display_on` in 1: visible-area flag from syncgen.
- `hblank_start` in 1: one-cycle pulse at the start of horizontal blanking.
- `frame_start` in 1: one-cycle pulse once per frame (vsync edge).
- `pos_we` in 1: shadow position write strobe.
- `pos_sel` in `IDX_W`: sprite index for the write.
- `pos_x` in 10: X of the sprite's left edge.
- `pos_y` in 10: Y of the sprite's top line.
- `pos_en` in 1: sprite visible.
- `rom_sprite` out `IDX_W`: bitmap ROM sprite select.
- `rom_line` out `$clog2(SPRITE_H)`: bitmap ROM line select.
- `rom_bits` in `4*SPRITE_W`: ROM data; registered ROM, valid one cycle after the address.
- `red`, `green`, `blue`, `alpha` out 1 each: composited pixel, registered.
- `hit_index` out `IDX_W`: index of the winning sprite (0 when `alpha`=0).
- `collision` out `NUM_SPRITES`: sticky per-sprite collision flags.
- `busy` out 1: line fetch in progress.

## Operation

- Pixel format: 4 bits `{R,G,B,A}` per pixel. Pixel 0 (leftmost) occupies `rom_bits[4*SPRITE_W-1 -: 4]`. A=1 means opaque.
- Position registers: `pos_we` writes `{pos_x,pos_y,pos_en}` into shadow[`pos_sel`]. `frame_start` copies every shadow register to its active register.
  - `pos_we` and `frame_start` in the same cycle: the active register takes the old shadow value; the new write lands in shadow and takes effect next frame.
  - `pos_sel` ≥ `NUM_SPRITES`: the write is ignored.
- Fetch FSM states: IDLE, ISSUE, CAPTURE.
  - IDLE → ISSUE on `hblank_start`, with sprite counter i=0.
  - `next_line` = (`vpos`==`V_TOTAL`-1) ? 0 : `vpos`+1, latched on entry.
  - ISSUE: drive `rom_sprite`=i and `rom_line`=(`next_line`−y_i)[low bits].
  - CAPTURE: if en_i && `next_line`≥y_i && `next_line`−y_i<`SPRITE_H`, load linebuf[i]←`rom_bits`; otherwise load linebuf[i]←0 (fully transparent).
  - After CAPTURE, i++ → ISSUE, or → IDLE after the last sprite.
  - `hblank_start` while not IDLE is ignored.
- Vertical clip: no wrap. A sprite with y near the bottom is truncated; it does not reappear at line 0.
- Horizontal: dx_i = `hpos`−x_i, compared unsigned after checking `hpos`≥x_i. Sprite i covers the pixel when dx_i<`SPRITE_W`. No wrap past the right edge.
- Priority: the lowest-index covering sprite with A=1 wins.
  - Winner present: output its R,G,B, `alpha`=1, `hit_index`=winner.
  - No winner: all colour outputs 0, `alpha`=0, `hit_index`=0.
  - `display_on`=0 forces all pixel outputs to 0.
- Collision: when `display_on` and ≥2 sprites are opaque at the same pixel, set `collision[k]` for every opaque sprite k. Flags are sticky.
  - `frame_start` clears all flags.
  - A collision in the same cycle as `frame_start` is still recorded: clear first, then OR.
- Reset: all shadow and active registers, linebufs, `collision`, and pixel outputs go to 0. `rom_sprite`/`rom_line` go to 0, `busy`=0, FSM returns to IDLE, including mid-fetch.

## Timing

- Pixel path latency: 1 clk. Outputs at cycle t+1 reflect `hpos`/`vpos`/`display_on` sampled at cycle t.
- Fetch sequence, with `hblank_start` sampled at cycle t:
  - ISSUE for sprite i at t+1+2i.
  - CAPTURE for sprite i at t+2+2i.
  - `busy` is high over t+1 … t+2N, and low from t+2N+1.
- Fetch must finish inside hblank: 2N+1 ≤ 160 cycles at 640×480. This holds for all legal N.
- Active positions change only on the cycle after `frame_start`.
- `collision` updates 1 clk after the overlapping pixel.

## Test plan

- Reset then idle → all outputs 0, `busy`=0. After `hblank_start`, `busy`=1 for exactly 2·`NUM_SPRITES` cycles.
- Sprite 0 at (100,150), enabled, ROM line all `4'b1001` (opaque red) → `red`=1, `alpha`=1 for `hpos` 100..115 on `vpos` 150..165. Pixel at `hpos`=116 and `vpos`=166 → 0.
- Sprites 0 and 1 both at (200,50), both opaque → colour from sprite 0, `hit_index`=0, `collision`=4'b0011. `frame_start` → `collision`=0. Repeat with sprite 1 transparent → `collision` stays 0.
- `pos_we` to sprite 2 coinciding with `frame_start` → new position not visible this frame, visible after the next `frame_start`.
- Sprite at y=520 with `V_TOTAL`=525 → lines 520..524 drawn, nothing on lines 0..10. Fetch on `vpos`=524 uses `next_line`=0.
- `reset` asserted at cycle t+3 of a fetch → FSM in IDLE and linebufs 0 next cycle, no pixels output afterwards.

Source files
------------

// File: rtl/multi_sprite_renderer.sv
// multi_sprite_renderer
//   Composites NUM_SPRITES RGBA sprites onto the VGA raster. During
//   horizontal blanking a small FSM walks the sprites, reads one bitmap line
//   per sprite from an external registered ROM into per-sprite line buffers,
//   and during the visible area the lowest-index opaque sprite wins each
//   pixel. Overlapping opaque sprites raise sticky collision flags that clear
//   at frame start. Positions are double-buffered (shadow -> active at
//   frame_start) so a frame never mixes old and new positions.
//
// Ports
//   clk, reset            pixel clock, synchronous active-high reset
//   hpos, vpos            raster position from the sync generator
//   display_on            visible-area flag
//   hblank_start          one-cycle pulse starting a line fetch
//   frame_start           one-cycle pulse; commits shadow positions, clears flags
//   pos_we/sel/x/y/en     shadow position write port
//   rom_sprite, rom_line  bitmap ROM address (data returns one cycle later)
//   rom_bits              ROM line data, pixel 0 in the top nibble {R,G,B,A}
//   red/green/blue/alpha  registered composited pixel
//   hit_index             winning sprite (0 when alpha=0)
//   collision             sticky per-sprite collision flags
//   busy                  line fetch in progress
module multi_sprite_renderer #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 16,
  parameter int SPRITE_H    = 16,
  parameter int V_TOTAL     = 525,
  parameter int IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  localparam int LINE_W     = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1,
  localparam int BITS_W     = 4 * SPRITE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [9:0]             hpos,
  input  logic [9:0]             vpos,
  input  logic                   display_on,
  input  logic                   hblank_start,
  input  logic                   frame_start,
  input  logic                   pos_we,
  input  logic [IDX_W-1:0]       pos_sel,
  input  logic [9:0]             pos_x,
  input  logic [9:0]             pos_y,
  input  logic                   pos_en,
  output logic [IDX_W-1:0]       rom_sprite,
  output logic [LINE_W-1:0]      rom_line,
  input  logic [BITS_W-1:0]      rom_bits,
  output logic                   red,
  output logic                   green,
  output logic                   blue,
  output logic                   alpha,
  output logic [IDX_W-1:0]       hit_index,
  output logic [NUM_SPRITES-1:0] collision,
  output logic                   busy
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  logic [9:0]        r_sh_x   [NUM_SPRITES];
  logic [9:0]        r_sh_y   [NUM_SPRITES];
  logic              r_sh_en  [NUM_SPRITES];
  logic [9:0]        r_act_x  [NUM_SPRITES];
  logic [9:0]        r_act_y  [NUM_SPRITES];
  logic              r_act_en [NUM_SPRITES];
  logic [BITS_W-1:0] r_linebuf[NUM_SPRITES];

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_cnt;
  logic [9:0]        r_next_line;

  logic [9:0]        w_sel_y;
  logic              w_sel_en;
  logic [9:0]        w_dy;
  logic              w_in_range;

  logic [9:0]        w_dx   [NUM_SPRITES];
  logic [BITS_W-1:0] w_shift[NUM_SPRITES];
  logic [3:0]        w_pix  [NUM_SPRITES];
  logic [NUM_SPRITES-1:0] w_opaque;
  logic [IDX_W-1:0]  w_win;
  logic [3:0]        w_win_pix;
  logic              w_multi;

  // Position registers: the frame_start copy reads the pre-write shadow, so a
  // simultaneous write only becomes active on the following frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        r_sh_x[k]   <= '0;
        r_sh_y[k]   <= '0;
        r_sh_en[k]  <= 1'b0;
        r_act_x[k]  <= '0;
        r_act_y[k]  <= '0;
        r_act_en[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < NUM_SPRITES; k++) begin
        if (frame_start) begin
          r_act_x[k]  <= r_sh_x[k];
          r_act_y[k]  <= r_sh_y[k];
          r_act_en[k] <= r_sh_en[k];
        end
        // Indices with no matching k (>= NUM_SPRITES) fall through unwritten.
        if (pos_we && pos_sel == IDX_W'(k)) begin
          r_sh_x[k]  <= pos_x;
          r_sh_y[k]  <= pos_y;
          r_sh_en[k] <= pos_en;
        end
      end
    end
  end

  // Fetch address generation for the sprite currently being walked.
  always_comb begin
    w_sel_y  = '0;
    w_sel_en = 1'b0;
    for (int k = 0; k < NUM_SPRITES; k++) begin
      if (r_cnt == IDX_W'(k)) begin
        w_sel_y  = r_act_y[k];
        w_sel_en = r_act_en[k];
      end
    end
  end

  assign w_dy       = r_next_line - w_sel_y;
  // No vertical wrap: a sprite near the bottom is simply truncated.
  assign w_in_range = w_sel_en && (r_next_line >= w_sel_y) && (w_dy < 10'(SPRITE_H));
  assign rom_sprite = r_cnt;
  assign rom_line   = w_dy[LINE_W-1:0];
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_next_line <= '0;
      for (int k = 0; k < NUM_SPRITES; k++) r_linebuf[k] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (hblank_start) begin
            r_state     <= S_ISSUE;
            r_cnt       <= '0;
            r_next_line <= (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
          end
        end
        S_ISSUE: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          // ROM data addressed in ISSUE is valid now; out-of-range lines
          // load a fully transparent buffer.
          for (int k = 0; k < NUM_SPRITES; k++) begin
            if (r_cnt == IDX_W'(k)) r_linebuf[k] <= w_in_range ? rom_bits : '0;
          end
          if (r_cnt == IDX_W'(NUM_SPRITES - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_ISSUE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Per-sprite pixel extraction: shifting the line left by 4*dx brings the
  // addressed pixel to the top nibble; shifts past the line yield zero.
  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_spr
    assign w_dx[g]     = hpos - r_act_x[g];
    assign w_shift[g]  = r_linebuf[g] << {w_dx[g], 2'b00};
    assign w_pix[g]    = ((hpos >= r_act_x[g]) && (w_dx[g] < 10'(SPRITE_W)))
                         ? w_shift[g][BITS_W-1 -: 4] : 4'd0;
    assign w_opaque[g] = w_pix[g][0];
  end

  // Scan from the highest index down so the lowest opaque index wins.
  always_comb begin
    w_win     = '0;
    w_win_pix = '0;
    for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
      if (w_opaque[k]) begin
        w_win     = IDX_W'(k);
        w_win_pix = w_pix[k];
      end
    end
  end

  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_multi = |(w_opaque & (w_opaque - 1'b1));

  always_ff @(posedge clk) begin
    if (reset) begin
      red       <= 1'b0;
      green     <= 1'b0;
      blue      <= 1'b0;
      alpha     <= 1'b0;
      hit_index <= '0;
      collision <= '0;
    end else begin
      if (display_on && (|w_opaque)) begin
        red       <= w_win_pix[3];
        green     <= w_win_pix[2];
        blue      <= w_win_pix[1];
        alpha     <= 1'b1;
        hit_index <= w_win;
      end else begin
        red       <= 1'b0;
        green     <= 1'b0;
        blue      <= 1'b0;
        alpha     <= 1'b0;
        hit_index <= '0;
      end
      // Clear at frame start first, then OR in this cycle's overlap.
      collision <= (frame_start ? '0 : collision)
                 | ((display_on && w_multi) ? w_opaque : '0);
    end
  end

endmodule

// File: tb/tb_multi_sprite_renderer.sv
module tb_multi_sprite_renderer;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hpos, vpos;
  logic        display_on, hblank_start, frame_start;
  logic        pos_we;
  logic [1:0]  pos_sel;
  logic [9:0]  pos_x, pos_y;
  logic        pos_en;
  logic [1:0]  rom_sprite;
  logic [3:0]  rom_line;
  logic [63:0] rom_bits;
  logic        red, green, blue, alpha;
  logic [1:0]  hit_index;
  logic [3:0]  collision;
  logic        busy;

  logic [63:0] rom_pat [N];
  int          errors = 0;
  int          checks = 0;
  int          n;

  multi_sprite_renderer #(.NUM_SPRITES(N), .SPRITE_W(16), .SPRITE_H(16), .V_TOTAL(525)) dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hblank_start(hblank_start), .frame_start(frame_start),
    .pos_we(pos_we), .pos_sel(pos_sel), .pos_x(pos_x), .pos_y(pos_y), .pos_en(pos_en),
    .rom_sprite(rom_sprite), .rom_line(rom_line), .rom_bits(rom_bits),
    .red(red), .green(green), .blue(blue), .alpha(alpha),
    .hit_index(hit_index), .collision(collision), .busy(busy)
  );

  always #5 clk = ~clk;

  // Registered bitmap ROM: every line of a sprite uses the same pattern.
  always @(posedge clk) rom_bits <= rom_pat[rom_sprite];

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pos(input logic [1:0] s, input logic [9:0] x, input logic [9:0] y, input logic en);
    pos_we = 1'b1; pos_sel = s; pos_x = x; pos_y = y; pos_en = en;
    tick();
    pos_we = 1'b0;
  endtask

  task automatic frame();
    display_on = 1'b0; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic fetch(input logic [9:0] v);
    display_on = 1'b0; vpos = v; hblank_start = 1'b1;
    tick();
    hblank_start = 1'b0;
    repeat (2 * N) tick();
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic on);
    hpos = h; vpos = v; display_on = on;
    tick();
  endtask

  initial begin
    reset = 1'b1; hpos = '0; vpos = '0; display_on = 1'b0; hblank_start = 1'b0;
    frame_start = 1'b0; pos_we = 1'b0; pos_sel = '0; pos_x = '0; pos_y = '0; pos_en = 1'b0;
    rom_pat[0] = 64'h9999_9999_9999_9999;  // opaque red
    rom_pat[1] = 64'h5555_5555_5555_5555;  // opaque green
    rom_pat[2] = 64'h3333_3333_3333_3333;  // opaque blue
    rom_pat[3] = 64'hFFFF_FFFF_FFFF_FFFF;  // opaque white
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_alpha", alpha, 0);
    check("rst_rgb", {red, green, blue}, 0);
    check("rst_hit", hit_index, 0);
    check("rst_coll", collision, 0);
    check("rst_busy", busy, 0);
    check("rst_rom", {rom_sprite, rom_line}, 0);

    // Busy lasts exactly 2*N cycles
    vpos = 10'd10; hblank_start = 1'b1;
    tick();
    hblank_start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      n++;
      tick();
    end
    check("busy_len", n, 2 * N);

    // Single sprite at (100,150)
    set_pos(2'd0, 10'd100, 10'd150, 1'b1);
    frame();
    fetch(10'd149);
    pix(10'd100, 10'd150, 1'b1);
    check("s0_left", {red, green, blue, alpha}, 4'b1001);
    pix(10'd115, 10'd150, 1'b1);
    check("s0_right", {red, alpha}, 2'b11);
    pix(10'd116, 10'd150, 1'b1);
    check("s0_past_right", {red, alpha}, 2'b00);
    pix(10'd99, 10'd150, 1'b1);
    check("s0_before_left", alpha, 0);
    pix(10'd105, 10'd150, 1'b0);
    check("s0_display_off", {red, alpha}, 2'b00);

    // ROM line select: next_line 155, y 150 -> line 5 on sprite 0 ISSUE
    vpos = 10'd154; hblank_start = 1'b1;
    tick();
    hblank_start = 1'b0;
    check("issue_line", {rom_sprite, rom_line}, {2'd0, 4'd5});
    repeat (2 * N) tick();

    fetch(10'd164);
    pix(10'd105, 10'd165, 1'b1);
    check("s0_last_line", {red, alpha}, 2'b11);
    fetch(10'd165);
    pix(10'd105, 10'd166, 1'b1);
    check("s0_below", alpha, 0);

    // Two overlapping opaque sprites at (200,50)
    set_pos(2'd0, 10'd200, 10'd50, 1'b1);
    set_pos(2'd1, 10'd200, 10'd50, 1'b1);
    frame();
    fetch(10'd49);
    pix(10'd205, 10'd50, 1'b1);
    check("ovl_color", {red, green, blue, alpha}, 4'b1001);
    check("ovl_hit", hit_index, 0);
    check("ovl_coll", collision, 4'b0011);
    pix(10'd300, 10'd50, 1'b1);
    check("coll_sticky", collision, 4'b0011);
    frame();
    check("coll_clear", collision, 0);
    // Overlap in the same cycle as frame_start is still recorded
    hpos = 10'd205; vpos = 10'd50; display_on = 1'b1; frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("coll_at_frame", collision, 4'b0011);
    frame();
    check("coll_clear2", collision, 0);

    // Sprite 1 transparent: no collision
    rom_pat[1] = 64'h4444_4444_4444_4444;
    fetch(10'd49);
    pix(10'd205, 10'd50, 1'b1);
    check("transp_coll", collision, 0);
    check("transp_color", {red, green, alpha}, 3'b101);

    // Sprite 1 at 190: only sprite 1 at 195, both at 202
    rom_pat[1] = 64'h5555_5555_5555_5555;
    set_pos(2'd1, 10'd190, 10'd50, 1'b1);
    frame();
    fetch(10'd49);
    pix(10'd195, 10'd50, 1'b1);
    check("s1_only", {red, green, alpha, hit_index}, {3'b011, 2'd1});
    check("s1_only_coll", collision, 0);
    pix(10'd202, 10'd50, 1'b1);
    check("prio_s0", {red, green, hit_index}, {2'b10, 2'd0});
    check("prio_coll", collision, 4'b0011);

    // Shadow write coinciding with frame_start
    pos_we = 1'b1; pos_sel = 2'd2; pos_x = 10'd300; pos_y = 10'd60; pos_en = 1'b1;
    display_on = 1'b0; frame_start = 1'b1;
    tick();
    pos_we = 1'b0; frame_start = 1'b0;
    fetch(10'd59);
    pix(10'd305, 10'd60, 1'b1);
    check("shadow_not_yet", alpha, 0);
    frame();
    fetch(10'd59);
    pix(10'd305, 10'd60, 1'b1);
    check("shadow_active", {red, green, blue, alpha, hit_index}, {4'b0011, 2'd2});

    // Sprite 3 near the bottom: truncated, no wrap
    set_pos(2'd3, 10'd400, 10'd520, 1'b1);
    frame();
    fetch(10'd523);
    pix(10'd400, 10'd524, 1'b1);
    check("bottom_line", {red, green, blue, alpha, hit_index}, {4'b1111, 2'd3});
    // vpos 524 wraps next_line to 0: sprite 0 at y=50 -> (0-50) mod 16 = 14
    vpos = 10'd524; hblank_start = 1'b1; display_on = 1'b0;
    tick();
    hblank_start = 1'b0;
    check("wrap_line", {rom_sprite, rom_line}, {2'd0, 4'd14});
    repeat (2 * N) tick();
    pix(10'd400, 10'd0, 1'b1);
    check("no_wrap_l0", alpha, 0);
    fetch(10'd9);
    pix(10'd400, 10'd10, 1'b1);
    check("no_wrap_l10", alpha, 0);

    // Reset in the middle of a fetch
    fetch(10'd523);
    vpos = 10'd523; hblank_start = 1'b1;
    tick();
    hblank_start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_out", {red, green, blue, alpha, hit_index}, 0);
    pix(10'd400, 10'd524, 1'b1);
    check("midrst_pix", alpha, 0);
    repeat (4) tick();
    check("midrst_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
